// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, runs a fixed-latency busy window per
// mult/div, commits the buffered 64-bit result at the end and raises decode stall.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic        r_pend_wr;
  logic        w_md_op, w_accept, w_commit, w_res_wr;
  logic [63:0] w_res;

  function automatic logic [63:0] mul_signed(input logic [31:0] x, input logic [31:0] y);
    return 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Returns {remainder, quotient}; a zero divisor is replaced by 1 so the
  // datapath never evaluates x/0 (that result is discarded at commit anyway).
  function automatic logic [63:0] div_unsigned(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = (y == 32'd0) ? 32'd1 : y;
    return {x % d, x / d};
  endfunction

  // Sign-magnitude divide: 0x80000000 / -1 falls out as quotient 0x80000000, rem 0.
  function automatic logic [63:0] div_signed(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] x_mag, y_mag, q, r;
    logic [63:0] rq;
    x_mag = x[31] ? (~x + 32'd1) : x;
    y_mag = y[31] ? (~y + 32'd1) : y;
    rq    = div_unsigned(x_mag, y_mag);
    q     = (x[31] ^ y[31]) ? (~rq[31:0] + 32'd1) : rq[31:0];
    r     = x[31] ? (~rq[63:32] + 32'd1) : rq[63:32];
    return {r, q};
  endfunction

  assign busy     = (r_state == S_BUSY);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign w_md_op  = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_DIV) | (op == OP_DIVU);
  assign w_accept = (r_state == S_IDLE) & start & ~req & (op != 3'd0) & (op != 3'd7);
  assign w_commit = (r_state == S_BUSY) & (r_cnt == 4'd1);
  assign stall    = md_use & (busy | (start & w_md_op & ~req));

  always_comb begin
    w_res    = 64'd0;
    w_res_wr = 1'b1;
    case (op)
      OP_MULT:  w_res = mul_signed(a, b);
      OP_MULTU: w_res = mul_unsigned(a, b);
      OP_DIV: begin
        w_res    = div_signed(a, b);
        w_res_wr = (b != 32'd0);
      end
      OP_DIVU: begin
        w_res    = div_unsigned(a, b);
        w_res_wr = (b != 32'd0);
      end
      default: w_res = 64'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_md_op) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_LAT : DIV_LAT;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (w_commit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept && w_md_op) begin
        r_pend_hi <= w_res[63:32];
        r_pend_lo <= w_res[31:0];
        r_pend_wr <= w_res_wr;
      end
      if (w_commit && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else if (w_accept && (op == OP_MTHI)) begin
        r_hi <= a;
      end else if (w_accept && (op == OP_MTLO)) begin
        r_lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a cycle-level reference model built from
// plain 64-bit arithmetic queues expected outputs; a negedge monitor compares.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0, req = 1'b0, start = 1'b0, md_use = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .op(op), .a(a), .b(b),
    .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          chk;
    bit          busy;
    bit          stall;
    logic [31:0] hi;
    logic [31:0] lo;
  } item_t;

  item_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  bit    done = 0;

  // Reference model state: visible HI/LO, one pending update, last busy cycle.
  logic [31:0] vis_hi = 0, vis_lo = 0, pend_hi = 0, pend_lo = 0;
  bit          pend_valid = 0;
  int          pend_due = 0;
  int          busy_until = 0;
  bit          known = 0;

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0]     qv, rv;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd1: return 64'(sx * sy);
      3'd2: return 64'(ux * uy);
      3'd3: begin q = sx / sy; r = sx % sy; qv = q; rv = r; return {rv[31:0], qv[31:0]}; end
      default: begin qv = ux / uy; rv = ux % uy; return {rv[31:0], qv[31:0]}; end
    endcase
  endfunction

  task automatic step(input bit rst, input bit st, input bit rq, input logic [2:0] o,
                      input logic [31:0] aa, input logic [31:0] bb, input bit mu);
    item_t       it;
    bit          idle;
    logic [63:0] res;
    @(posedge clk);
    #1;
    reset = rst; start = st; req = rq; op = o; a = aa; b = bb; md_use = mu;
    if (pend_valid && pend_due == cyc) begin
      vis_hi = pend_hi; vis_lo = pend_lo; pend_valid = 0;
    end
    idle     = (cyc > busy_until);
    it.cyc   = cyc;
    it.chk   = known;
    it.busy  = !idle;
    it.stall = mu && (!idle || (st && o >= 3'd1 && o <= 3'd4 && !rq));
    it.hi    = vis_hi;
    it.lo    = vis_lo;
    exp_q.push_back(it);
    if (rst) begin
      known = 1; pend_valid = 1; pend_due = cyc + 1; pend_hi = 0; pend_lo = 0;
      busy_until = cyc;
    end else if (idle && st && !rq) begin
      if (o >= 3'd1 && o <= 3'd4) begin
        busy_until = cyc + ((o <= 3'd2) ? MC : DC);
        pend_valid = 1;
        pend_due   = busy_until + 1;
        if (o >= 3'd3 && bb == 32'd0) begin
          pend_hi = vis_hi; pend_lo = vis_lo;
        end else begin
          res = ref_result(o, aa, bb);
          pend_hi = res[63:32]; pend_lo = res[31:0];
        end
      end else if (o == 3'd5 || o == 3'd6) begin
        pend_valid = 1;
        pend_due   = cyc + 1;
        pend_hi    = (o == 3'd5) ? aa : vis_hi;
        pend_lo    = (o == 3'd6) ? aa : vis_lo;
      end
    end
  endtask

  task automatic idle_n(input int n, input bit mu);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 32'd0, 32'd0, mu);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    item_t it;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      it = exp_q.pop_front();
      if (it.chk) begin
        check("busy", {31'd0, busy}, {31'd0, it.busy});
        check("stall", {31'd0, stall}, {31'd0, it.stall});
        check("hi", hi, it.hi);
        check("lo", lo, it.lo);
      end
    end
    if (done) begin
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    step(1, 0, 0, 3'd0, 0, 0, 0);
    step(1, 0, 0, 3'd0, 0, 0, 0);
    // mult -2*3 with md_use held high across the whole window
    step(0, 1, 0, 3'd1, 32'hFFFFFFFE, 32'd3, 1);
    idle_n(MC + 2, 1);
    step(0, 1, 0, 3'd2, 32'hFFFFFFFF, 32'd2, 0);
    idle_n(MC + 1, 0);
    step(0, 1, 0, 3'd3, 32'hFFFFFFF9, 32'd2, 0);
    idle_n(DC + 1, 0);
    step(0, 1, 0, 3'd4, 32'h55, 32'd0, 0);
    idle_n(DC + 1, 0);
    step(0, 1, 0, 3'd5, 32'h12345678, 0, 0);
    step(0, 1, 0, 3'd6, 32'h9, 0, 0);
    idle_n(2, 0);
    // start suppressed by exception request
    step(0, 1, 1, 3'd1, 32'd7, 32'd9, 1);
    idle_n(2, 1);
    // req during an active div does not cancel it
    step(0, 1, 0, 3'd3, 32'd100, 32'hFFFFFFF9, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 3'd0, 0, 0, 0);
    step(0, 1, 0, 3'd6, 32'hDEAD, 0, 1);
    idle_n(DC, 0);
    step(0, 1, 0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    idle_n(DC + 1, 0);
    // reset on busy cycle 3 aborts the mult
    step(0, 1, 0, 3'd1, 32'd1234, 32'd5678, 1);
    idle_n(2, 1);
    step(1, 0, 0, 3'd0, 0, 0, 1);
    idle_n(2, 1);
    step(0, 1, 0, 3'd2, 32'h80000000, 32'h80000000, 0);
    idle_n(MC + 1, 0);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    idle_n(DC + 2, 0);
    done = 1;
  end
endmodule
